// File: rtl/uart_alu_ctrl.sv
// Sequences RX bytes (A, B, opcode) into the ALU and sends the result back through TX.
// Latency: tx_start pulses 2 cycles after the opcode byte is accepted.
// Backpressure: RX has no stall; bytes arriving while busy computing/sending are dropped and flagged.
// Optional feature macro: UART_CTRL_TIMEOUT_EN (inter-byte timeout in GET_B/GET_OP).
module uart_alu_ctrl #(
    parameter int DBIT           = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DBIT-1:0]    rx_data,
    input  logic               rx_done,
    input  logic               tx_done,
    input  logic [DBIT-1:0]    alu_result,
    output logic [DBIT-1:0]    alu_a,
    output logic [DBIT-1:0]    alu_b,
    output logic [OP_BITS-1:0] alu_op,
    output logic [DBIT-1:0]    tx_data,
    output logic               tx_start,
    output logic               busy,
    output logic               byte_dropped,
    output logic               timeout
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                rx_q, tx_q;
    logic                rx_ev, tx_ev;
    logic [DBIT-1:0]     alu_a_q, alu_a_d;
    logic [DBIT-1:0]     alu_b_q, alu_b_d;
    logic [OP_BITS-1:0]  alu_op_q, alu_op_d;
    logic [DBIT-1:0]     tx_data_q, tx_data_d;
    logic                drop;

`ifdef UART_CTRL_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] cnt_q, cnt_d;
    logic        to_hit;
`endif

    // RX/TX done flags are levels; only their rising edges are events.
    assign rx_ev = rx_done & ~rx_q;
    assign tx_ev = tx_done & ~tx_q;

    // Edge-detect history registers, sampled every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q <= 1'b0;
            tx_q <= 1'b0;
        end else begin
            rx_q <= rx_done;
            tx_q <= tx_done;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= GET_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
        end
    end

`ifdef UART_CTRL_TIMEOUT_EN
    // Inter-byte timeout counter; next value is computed in the FSM block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state, register loads and event-driven pulses.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        drop      = 1'b0;
`ifdef UART_CTRL_TIMEOUT_EN
        // Zero by default: clears on entry to the counting states, on accept and on expiry.
        cnt_d     = '0;
        to_hit    = 1'b0;
`endif
        case (state_q)
            GET_A: begin
                if (rx_ev) begin
                    alu_a_d = rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (rx_ev) begin
                    alu_b_d = rx_data;
                    state_d = GET_OP;
                end
`ifdef UART_CTRL_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = GET_A;
                    to_hit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            GET_OP: begin
                if (rx_ev) begin
                    alu_op_d = rx_data[OP_BITS-1:0];
                    state_d  = EXEC;
                end
`ifdef UART_CTRL_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = GET_A;
                    to_hit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            EXEC: begin
                // Operands have been stable for a full cycle; capture the ALU output.
                tx_data_d = alu_result;
                state_d   = SEND;
                drop      = rx_ev;
            end
            SEND: begin
                state_d = WAIT_TX;
                drop    = rx_ev;
            end
            WAIT_TX: begin
                if (tx_ev) begin
                    state_d = GET_A;
                end
                drop = rx_ev;
            end
            default: begin
                state_d = GET_A;
            end
        endcase
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = (state_q == SEND);
    assign busy         = (state_q != GET_A);
    assign byte_dropped = drop;
`ifdef UART_CTRL_TIMEOUT_EN
    assign timeout      = to_hit;
`else
    assign timeout      = 1'b0;
`endif

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Sequencing controller between the UART receiver/transmitter and the ALU.
- Collects three bytes from RX: operand A, operand B, opcode.
- Presents them to the ALU, captures the result and commands TX to send it back.
- Sits in the top level between RX (d_out/rx_done), the combinational ALU and TX (tx_start/tx_done).

Parameters:
DBIT, 8, data byte width (operands, result, RX/TX data).
OP_BITS, 6, opcode width; taken from the low OP_BITS of the third received byte.
TIMEOUT_CYCLES, 50000000, inter-byte timeout in clk cycles; used only with UART_CTRL_TIMEOUT_EN.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
rx_data  input  DBIT  received byte from RX d_out; valid when rx_done rises.
rx_done  input  1  RX byte-complete flag; level may persist several cycles, so only its rising edge counts.
tx_done  input  1  TX frame-complete flag; only its rising edge counts.
alu_result  input  DBIT  combinational ALU output.
alu_a  output  DBIT  registered operand A to ALU.
alu_b  output  DBIT  registered operand B to ALU.
alu_op  output  OP_BITS  registered opcode to ALU.
tx_data  output  DBIT  byte to transmit, registered.
tx_start  output  1  single-cycle pulse requesting TX to send tx_data.
busy  output  1  high in every state except GET_A.
byte_dropped  output  1  single-cycle pulse: RX byte arrived while not accepting.
timeout  output  1  single-cycle pulse on inter-byte timeout; constant 0 without the macro.

Behaviour:
- Reset (async, immediate): state=GET_A; alu_a=alu_b=0, alu_op=0, tx_data=0, tx_start=0, byte_dropped=0, timeout=0; edge-detect registers rx_q=tx_q=0; timeout counter=0.
- rx_ev = rx_done & ~rx_q; tx_ev = tx_done & ~tx_q; rx_q/tx_q register inputs every cycle. A rx_done already high when reset deasserts produces one event on the first cycle.
- GET_A: rx_ev -> alu_a<=rx_data, goto GET_B.
- GET_B: rx_ev -> alu_b<=rx_data, goto GET_OP.
- GET_OP: rx_ev -> alu_op<=rx_data[OP_BITS-1:0] (upper bits ignored), goto EXEC.
- EXEC: one settle cycle; tx_data<=alu_result; goto SEND.
- SEND: tx_start=1 for exactly this cycle; goto WAIT_TX.
- WAIT_TX: tx_ev -> goto GET_A; otherwise hold. tx_ev in any other state is ignored.
- Latency: tx_start rises 2 cycles after the cycle in which the opcode rx_ev is seen.
- rx_ev in EXEC, SEND or WAIT_TX: byte discarded, byte_dropped pulses 1 cycle, registers unchanged.
- rx_ev and tx_ev in the same WAIT_TX cycle: goto GET_A and the byte is dropped (byte_dropped=1).
- alu_a/alu_b/alu_op/tx_data hold their values until overwritten; they are not cleared on return to GET_A.
- Reset mid-transaction: abort immediately; a partially received triple is discarded.

Optional Feature:
UART_CTRL_TIMEOUT_EN
- Defined:
  - In GET_B and GET_OP, a 32-bit counter increments every clk cycle.
  - The counter clears on entry to those states and on each accepted rx_ev.
  - When count reaches TIMEOUT_CYCLES-1: goto GET_A, timeout pulses 1 cycle, counter clears.
  - An rx_ev in the same cycle as the timeout wins: byte accepted, no timeout.
- Not defined: no counter logic, timeout tied to 0, GET_B/GET_OP wait indefinitely.

Test Plan:
- Basic transaction: reset, bytes 0x05, 0x03, 0x20 via rx_done pulses; ALU stub adds (result 0x08) -> alu_a=0x05, alu_b=0x03, alu_op=0x20, tx_data=0x08, one tx_start pulse 2 cycles after third rx_ev; busy stays high until tx_done rises.
- Long rx_done level: hold rx_done high 20 cycles per byte for 0xFF, 0x01, 0x3F -> exactly one byte accepted per assertion; alu_op=0x3F; single transaction, no byte_dropped.
- Opcode masking: third byte 0xE2 -> alu_op=0x22.
- Overrun: send a 4th byte 0xAA while in WAIT_TX -> byte_dropped pulses once; alu_a stays at its previous value; after tx_done, the next byte 0x11 loads alu_a=0x11.
- Reset mid-operation: assert reset after operand B=0x44 -> all outputs 0, state GET_A; next three bytes start a fresh transaction.
- With UART_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100: send A=0x12, then idle 100 cycles -> timeout pulses at cycle 99 after acceptance, busy=0; next byte 0x34 loads alu_a=0x34. Without the macro the same stimulus leaves the block in GET_B with timeout=0.
